// File: rtl/matrix_pkg.sv
// Shared constants, FSM state type and pixel-extraction helper for the
// 5x7 LED matrix scan controller.
package matrix_pkg;

  localparam int NUM_COLS = 5;
  localparam int NUM_ROWS = 7;
  localparam int FRAME_W  = 36;
  localparam int EN_BIT   = 0;
  localparam int COL_W    = 3;

  typedef enum logic [0:0] {
    BLANK = 1'b0,
    DRIVE = 1'b1
  } scan_state_e;

  // Pixel p sits at frame bit p+1; column c owns pixels 7c..7c+6, so its
  // rows are frame bits [7c+7 : 7c+1]. Bit 0 is the enable and is skipped.
  function automatic logic [NUM_ROWS-1:0] col_bits(
    input logic [FRAME_W-1:0] frame,
    input logic [COL_W-1:0]   c
  );
    logic [FRAME_W-1:0] shifted;
    shifted = frame >> (NUM_ROWS * int'(c) + 1);
    return shifted[NUM_ROWS-1:0];
  endfunction

endpackage

// File: rtl/matrix_scan_controller_if.sv
// Frame-transfer handshake between a frame source and the scan controller.
interface matrix_scan_controller_if;
  import matrix_pkg::*;

  logic [FRAME_W-1:0] frame_in;
  logic               frame_valid;
  logic               frame_ready;

  modport master (
    output frame_in,
    output frame_valid,
    input  frame_ready
  );

  modport slave (
    input  frame_in,
    input  frame_valid,
    output frame_ready
  );

endinterface

// File: rtl/matrix_dwell_timer.sv
// Loadable down-counter used to time both the blanking gap and the column
// dwell. o_done is high while the count sits at zero, i.e. during the last
// cycle of the interval that was loaded with (length - 1).
module matrix_dwell_timer #(
  parameter int                 CNT_W     = 2,
  parameter logic [CNT_W-1:0]   RESET_VAL = '0
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  output logic             o_done,
  output logic [CNT_W-1:0] o_count
);

  logic [CNT_W-1:0] r_count;

  // Reload on request, otherwise count down and park at zero.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_count <= RESET_VAL;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (r_count != {CNT_W{1'b0}}) begin
      r_count <= r_count - CNT_W'(1);
    end else begin
      r_count <= r_count;
    end
  end

  assign o_done  = (r_count == {CNT_W{1'b0}});
  assign o_count = r_count;

endmodule

// File: rtl/matrix_scan_controller.sv
// Column-multiplexed driver for a 5x7 active-low LED matrix. Frames arrive
// over a valid/ready handshake into a pending buffer and are promoted to the
// displayed buffer only at the end of a full sweep, so a frame never tears.
module matrix_scan_controller
  import matrix_pkg::*;
#(
  parameter int DWELL_CYCLES = 50000,
  parameter int BLANK_CYCLES = 8
) (
  input  logic                      i_clk,
  input  logic                      i_reset,
  matrix_scan_controller_if.slave   i_frame_if,
  output logic [NUM_ROWS-1:0]       o_row_n,
  output logic [NUM_COLS-1:0]       o_col_n,
  output logic [COL_W-1:0]          o_col_idx,
  output logic                      o_sweep_done
);

  localparam int MAX_CYC = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
  localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam logic [CNT_W-1:0] DWELL_LOAD = CNT_W'(DWELL_CYCLES - 1);
  localparam logic [CNT_W-1:0] BLANK_LOAD = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [COL_W-1:0] LAST_COL   = COL_W'(NUM_COLS - 1);

  scan_state_e         r_state;
  scan_state_e         w_state_next;
  logic [COL_W-1:0]    r_col_idx;
  logic [COL_W-1:0]    w_col_next;
  logic                w_done;
  logic [CNT_W-1:0]    w_count;
  logic [CNT_W-1:0]    w_load_val;
  logic                w_next_last;
  logic                w_sweep_end;
  logic                w_xfer;
  logic [FRAME_W-1:0]  r_active;
  logic [FRAME_W-1:0]  r_pending;
  logic                r_pending_full;
  logic                r_frame_ready;
  logic [NUM_ROWS-1:0] w_row_n_next;
  logic [NUM_COLS-1:0] w_col_n_next;
  logic                w_sweep_next;
  logic [NUM_ROWS-1:0] r_row_n;
  logic [NUM_COLS-1:0] r_col_n;
  logic                r_sweep_done;

  // Every state change reloads the timer with the length of the new state.
  assign w_load_val = (w_state_next == DRIVE) ? DWELL_LOAD : BLANK_LOAD;

  matrix_dwell_timer #(
    .CNT_W     (CNT_W),
    .RESET_VAL (BLANK_LOAD)
  ) u_timer (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_load     (w_done),
    .i_load_val (w_load_val),
    .o_done     (w_done),
    .o_count    (w_count)
  );

  // The upcoming cycle is the last of its interval either because a freshly
  // loaded interval is one cycle long or because the running count is at 1.
  assign w_next_last = w_done ? (w_load_val == {CNT_W{1'b0}}) : (w_count == CNT_W'(1));
  assign w_sweep_end = (r_state == DRIVE) && w_done && (r_col_idx == LAST_COL);
  assign w_xfer      = i_frame_if.frame_valid && r_frame_ready;

  // FSM state and column index register.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state   <= BLANK;
      r_col_idx <= {COL_W{1'b0}};
    end else begin
      r_state   <= w_state_next;
      r_col_idx <= w_col_next;
    end
  end

  // Next state: BLANK -> DRIVE on the same column, DRIVE -> BLANK advancing the column.
  always_comb begin
    w_state_next = r_state;
    w_col_next   = r_col_idx;
    case (r_state)
      BLANK: begin
        if (w_done) begin
          w_state_next = DRIVE;
        end else begin
          w_state_next = BLANK;
        end
      end
      DRIVE: begin
        if (w_done) begin
          w_state_next = BLANK;
          w_col_next   = (r_col_idx == LAST_COL) ? {COL_W{1'b0}} : (r_col_idx + COL_W'(1));
        end else begin
          w_state_next = DRIVE;
        end
      end
      default: begin
        w_state_next = BLANK;
        w_col_next   = {COL_W{1'b0}};
      end
    endcase
  end

  // Output decode for the coming cycle; drive only a DRIVE column of an enabled frame.
  always_comb begin
    w_row_n_next = {NUM_ROWS{1'b1}};
    w_col_n_next = {NUM_COLS{1'b1}};
    if ((w_state_next == DRIVE) && r_active[EN_BIT]) begin
      w_row_n_next = ~col_bits(r_active, w_col_next);
      w_col_n_next = ~(NUM_COLS'(1) << w_col_next);
    end else begin
      w_row_n_next = {NUM_ROWS{1'b1}};
      w_col_n_next = {NUM_COLS{1'b1}};
    end
    w_sweep_next = (w_state_next == DRIVE) && (w_col_next == LAST_COL) && w_next_last;
  end

  // Registered display outputs so they change on the same edge as the FSM.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_row_n      <= {NUM_ROWS{1'b1}};
      r_col_n      <= {NUM_COLS{1'b1}};
      r_sweep_done <= 1'b0;
    end else begin
      r_row_n      <= w_row_n_next;
      r_col_n      <= w_col_n_next;
      r_sweep_done <= w_sweep_next;
    end
  end

  // Double buffer: accept into pending, promote to active only at sweep end.
  // A swap needs pending full while a transfer needs it empty, so they never collide.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_active       <= {FRAME_W{1'b0}};
      r_pending      <= {FRAME_W{1'b0}};
      r_pending_full <= 1'b0;
      r_frame_ready  <= 1'b1;
    end else if (w_sweep_end && r_pending_full) begin
      r_active       <= r_pending;
      r_pending_full <= 1'b0;
      r_frame_ready  <= 1'b1;
    end else if (w_xfer) begin
      r_pending      <= i_frame_if.frame_in;
      r_pending_full <= 1'b1;
      r_frame_ready  <= 1'b0;
    end else begin
      r_pending_full <= r_pending_full;
      r_frame_ready  <= r_frame_ready;
    end
  end

  assign i_frame_if.frame_ready = r_frame_ready;
  assign o_row_n      = r_row_n;
  assign o_col_n      = r_col_n;
  assign o_col_idx    = r_col_idx;
  assign o_sweep_done = r_sweep_done;

endmodule

// File: tb/tb_matrix_scan_controller.sv
// Self-checking bench for matrix_scan_controller. The reference model tracks
// time since reset and derives column/phase arithmetically from the sweep
// period, plus a two-slot frame buffer updated by the handshake rules.
module tb_matrix_scan_controller;
  import matrix_pkg::*;

  localparam int TB_DWELL = 4;
  localparam int TB_BLANK = 2;
  localparam int SLOT     = TB_DWELL + TB_BLANK;
  localparam int PERIOD   = NUM_COLS * SLOT;

  logic        clk = 1'b0;
  logic        reset;
  logic [6:0]  row_n;
  logic [4:0]  col_n;
  logic [2:0]  col_idx;
  logic        sweep_done;

  matrix_scan_controller_if bus ();

  matrix_scan_controller #(
    .DWELL_CYCLES (TB_DWELL),
    .BLANK_CYCLES (TB_BLANK)
  ) dut (
    .i_clk        (clk),
    .i_reset      (reset),
    .i_frame_if   (bus),
    .o_row_n      (row_n),
    .o_col_n      (col_n),
    .o_col_idx    (col_idx),
    .o_sweep_done (sweep_done)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_errors = 0;
  int          t = 0;
  logic [35:0] m_active  = 36'h0;
  logic [35:0] m_pending = 36'h0;
  bit          m_full    = 1'b0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s t=%0d got=%0h exp=%0h", tag, t, got, exp);
    end
  endtask

  task automatic check_outputs();
    int          phase;
    int          col;
    bit          drive;
    logic [6:0]  er;
    logic [4:0]  ec;
    logic [4:0]  one;
    phase = t % PERIOD;
    col   = phase / SLOT;
    drive = (phase % SLOT) >= TB_BLANK;
    er    = 7'h7F;
    ec    = 5'h1F;
    one   = 5'd1;
    if (drive && m_active[0]) begin
      ec = ~(one << col);
      er = ~m_active[7*col+1 +: 7];
    end
    check_eq("row_n",       64'(row_n),           64'(er));
    check_eq("col_n",       64'(col_n),           64'(ec));
    check_eq("col_idx",     64'(col_idx),         64'(col));
    check_eq("sweep_done",  64'(sweep_done),      64'(phase == PERIOD - 1));
    check_eq("frame_ready", 64'(bus.frame_ready), 64'(!m_full));
  endtask

  // One clock: apply inputs, advance the model across the edge, check after it.
  task automatic tick(input bit rst, input bit v, input logic [35:0] d, output bit acc);
    reset           = rst;
    bus.frame_valid = v;
    bus.frame_in    = d;
    acc             = 1'b0;
    if (rst) begin
      t         = 0;
      m_full    = 1'b0;
      m_active  = 36'h0;
      m_pending = 36'h0;
    end else begin
      if ((t % PERIOD) == PERIOD - 1 && m_full) begin
        m_active = m_pending;
        m_full   = 1'b0;
      end else if (v && !m_full) begin
        m_pending = d;
        m_full    = 1'b1;
        acc       = 1'b1;
      end
      t++;
    end
    @(negedge clk);
    check_outputs();
  endtask

  task automatic idle(input int n);
    bit acc;
    for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 36'h0, acc);
  endtask

  // Sender holds the frame until it is taken, within a cycle budget.
  task automatic send_frame(input logic [35:0] d);
    bit acc;
    bit done;
    done = 1'b0;
    for (int i = 0; i < 4 * PERIOD && !done; i++) begin
      tick(1'b0, 1'b1, d, acc);
      done = acc;
    end
    if (!done) check_eq("send_timeout", 64'd0, 64'd1);
  endtask

  task automatic wait_phase(input int ph, input bit need_empty);
    bit found;
    found = 1'b0;
    for (int i = 0; i < 4 * PERIOD && !found; i++) begin
      if ((t % PERIOD) == ph && (!need_empty || !m_full)) found = 1'b1;
      else idle(1);
    end
    if (!found) check_eq("phase_timeout", 64'd0, 64'd1);
  endtask

  function automatic logic [35:0] rnd_frame();
    logic [63:0] x;
    x = {$urandom(), $urandom()};
    return x[35:0];
  endfunction

  initial begin
    logic [35:0] f_disp;
    logic [35:0] f_off;
    logic [35:0] f_b;
    logic [35:0] rf;
    bit          acc;
    bit          holding;

    f_disp = {28'h0, 7'b1010101, 1'b1};
    f_off  = {35'h7FFFFFFFF, 1'b0};
    reset           = 1'b1;
    bus.frame_valid = 1'b0;
    bus.frame_in    = 36'h0;

    // Reset held three cycles, then free-running blank sweeps.
    for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, 36'h0, acc);
    idle(2 * PERIOD + 10);

    // Single-column pattern frame.
    send_frame(f_disp);
    idle(2 * PERIOD + 5);

    // Backpressure: A accepted, B held off until the pending slot drains.
    send_frame(rnd_frame() | 36'h1);
    f_b = rnd_frame() | 36'h1;
    send_frame(f_b);
    idle(2 * PERIOD + 3);

    // Enable bit cleared: all pixels set but the display stays dark.
    send_frame(f_off);
    idle(2 * PERIOD + 3);

    // Transfer exactly on the sweep_done cycle with the pending slot empty.
    wait_phase(PERIOD - 1, 1'b1);
    tick(1'b0, 1'b1, {35'h5A5A5A5A5, 1'b1}, acc);
    idle(2 * PERIOD + 4);

    // Randomized sender that holds each frame until accepted.
    holding = 1'b0;
    rf      = 36'h0;
    for (int i = 0; i < 12 * PERIOD; i++) begin
      if (!holding && $urandom_range(0, 3) == 0) begin
        holding = 1'b1;
        rf      = rnd_frame();
      end
      tick(1'b0, holding, rf, acc);
      if (acc) holding = 1'b0;
    end
    idle(2 * PERIOD);

    // Reset during column-2 drive with a frame pending: it must never appear.
    send_frame(36'hF_FFFF_FFFF);
    idle(2 * PERIOD);
    wait_phase(1, 1'b1);
    send_frame({35'h7FFFFFFFF, 1'b1});
    wait_phase(2 * SLOT + TB_BLANK + 1, 1'b0);
    tick(1'b1, 1'b0, 36'h0, acc);
    check_eq("mid_reset_ready", 64'(bus.frame_ready), 64'd1);
    check_eq("mid_reset_col_n", 64'(col_n), 64'h1F);
    idle(3 * PERIOD);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
